// File: rtl/i2c_target.sv
// I2C target endpoint: synchronises SDA/SCL, decodes START/STOP, matches a 7-bit
// address and moves bytes between the bus and a byte-wide local port. No clock stretching.
module i2c_target #(
    parameter int                    ADDR_WIDTH  = 7,
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [ADDR_WIDTH-1:0] TARGET_ADDR = 7'h42
) (
    input  logic                  clock,
    input  logic                  reset,
    inout  wire                   sda,
    inout  wire                   scl,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  tx_req,
    output logic                  busy,
    output logic                  nack_seen
);

    localparam logic [3:0] CNT_ADDR = 4'(ADDR_WIDTH + 1);
    localparam logic [3:0] CNT_BYTE = 4'(DATA_WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_WRITE, ST_WRITE_ACK, ST_READ, ST_READ_ACK
    } state_t;

    state_t                  state_q;
    logic [3:0]              bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   rx_data_q;
    logic                    rw_q, sda_oe_q, ack_pend_q;
    logic                    rx_valid_q, tx_req_q, busy_q, nack_q;
    logic                    sda_meta_q, sda_s_q, sda_prev_q;
    logic                    scl_meta_q, scl_s_q, scl_prev_q;

    // Open-drain pads: only ever pull SDA low; SCL is observed, never driven.
    assign sda = sda_oe_q ? 1'b0 : 1'bz;
    assign scl = 1'bz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sda_meta_q <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_meta_q <= 1'b1;
            scl_s_q    <= 1'b1;
            scl_prev_q <= 1'b1;
        end else begin
            sda_meta_q <= sda;
            sda_s_q    <= sda_meta_q;
            sda_prev_q <= sda_s_q;
            scl_meta_q <= scl;
            scl_s_q    <= scl_meta_q;
            scl_prev_q <= scl_s_q;
        end
    end

    logic scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_rise = ~scl_prev_q & scl_s_q;
    assign scl_fall = scl_prev_q & ~scl_s_q;
    assign start_ev = scl_prev_q & scl_s_q & sda_prev_q & ~sda_s_q;
    assign stop_ev  = scl_prev_q & scl_s_q & ~sda_prev_q & sda_s_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            ack_pend_q <= 1'b0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            nack_q     <= 1'b0;
            if (stop_ev) begin
                state_q    <= ST_IDLE;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                ack_pend_q <= 1'b0;
            end else if (start_ev) begin
                state_q    <= ST_ADDR;
                bit_cnt_q  <= '0;
                shift_q    <= '0;
                sda_oe_q   <= 1'b0;
                busy_q     <= 1'b0;
                ack_pend_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[DATA_WIDTH-2:0], sda_s_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (scl_fall && bit_cnt_q == CNT_ADDR) begin
                            if (shift_q[ADDR_WIDTH:1] == TARGET_ADDR) begin
                                sda_oe_q <= 1'b1;
                                busy_q   <= 1'b1;
                                rw_q     <= shift_q[0];
                                state_q  <= ST_ADDR_ACK;
                            end else begin
                                state_q  <= ST_IDLE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            if (rw_q) begin
                                shift_q   <= tx_data;
                                sda_oe_q  <= ~tx_data[DATA_WIDTH-1];
                                tx_req_q  <= 1'b1;
                                bit_cnt_q <= 4'd1;
                                state_q   <= ST_READ;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                bit_cnt_q <= '0;
                                state_q   <= ST_WRITE;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[DATA_WIDTH-2:0], sda_s_q};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            if (bit_cnt_q == CNT_BYTE - 4'd1) begin
                                rx_data_q  <= {shift_q[DATA_WIDTH-2:0], sda_s_q};
                                rx_valid_q <= 1'b1;
                                ack_pend_q <= 1'b1;
                            end
                        end else if (scl_fall && ack_pend_q) begin
                            sda_oe_q   <= 1'b1;
                            ack_pend_q <= 1'b0;
                            state_q    <= ST_WRITE_ACK;
                        end
                    end
                    ST_WRITE_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q  <= 1'b0;
                            bit_cnt_q <= '0;
                            state_q   <= ST_WRITE;
                        end
                    end
                    ST_READ: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == CNT_BYTE) begin
                                sda_oe_q <= 1'b0;
                                state_q  <= ST_READ_ACK;
                            end else begin
                                shift_q   <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                                sda_oe_q  <= ~shift_q[DATA_WIDTH-2];
                                bit_cnt_q <= bit_cnt_q + 4'd1;
                            end
                        end
                    end
                    ST_READ_ACK: begin
                        // A NACK leaves on the rise, so a fall here always follows a master ACK.
                        if (scl_rise && sda_s_q) begin
                            nack_q   <= 1'b1;
                            busy_q   <= 1'b0;
                            sda_oe_q <= 1'b0;
                            state_q  <= ST_IDLE;
                        end else if (scl_fall) begin
                            shift_q   <= tx_data;
                            sda_oe_q  <= ~tx_data[DATA_WIDTH-1];
                            tx_req_q  <= 1'b1;
                            bit_cnt_q <= 4'd1;
                            state_q   <= ST_READ;
                        end
                    end
                    default: begin
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_req    = tx_req_q;
    assign busy      = busy_q;
    assign nack_seen = nack_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a behavioural bus master with randomised transactions,
// checked against a transaction-level model of what the target should do.
module tb_i2c_target;

    localparam time QP = 100ns;
    localparam logic [6:0] TADDR = 7'h42;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid, tx_req, busy, nack_seen;
    logic       m_sda_oe, m_scl_oe;
    wire        sda_bus, scl_bus;

    pullup (sda_bus);
    pullup (scl_bus);
    assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;
    assign scl_bus = m_scl_oe ? 1'b0 : 1'bz;

    i2c_target dut (
        .clock     (clock),
        .reset     (reset),
        .sda       (sda_bus),
        .scl       (scl_bus),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_req    (tx_req),
        .busy      (busy),
        .nack_seen (nack_seen)
    );

    always #5ns clock = ~clock;

    int total = 0;
    int bad   = 0;
    int rxv_n = 0, txr_n = 0, nack_n = 0, low_n = 0, busy_n = 0, glitch_n = 0;
    logic sda_prev = 1'b1, scl_prev = 1'b1, oe_prev = 1'b0;
    logic [7:0] last_rx;

    // Event counters; tests take deltas across a transaction.
    always @(negedge clock) begin
        if (rx_valid === 1'b1)  rxv_n++;
        if (tx_req === 1'b1)    txr_n++;
        if (nack_seen === 1'b1) nack_n++;
        if (busy === 1'b1)      busy_n++;
        if (sda_bus === 1'b0 && !m_sda_oe) low_n++;
        if (scl_bus === 1'b1 && scl_prev === 1'b1 && sda_bus !== sda_prev && m_sda_oe == oe_prev)
            glitch_n++;
        sda_prev = sda_bus;
        scl_prev = scl_bus;
        oe_prev  = m_sda_oe;
    end

    task automatic m_clk(input logic b, output logic s);
        m_sda_oe = ~b;
        #QP m_scl_oe = 1'b0;
        #QP s = sda_bus;
        #QP m_scl_oe = 1'b1;
        #QP;
    endtask

    task automatic m_start();
        m_sda_oe = 1'b0;
        #QP m_scl_oe = 1'b0;
        #QP m_sda_oe = 1'b1;
        #QP m_scl_oe = 1'b1;
        #QP;
    endtask

    task automatic m_stop();
        m_sda_oe = 1'b1;
        #QP m_scl_oe = 1'b0;
        #QP m_sda_oe = 1'b0;
        #QP;
    endtask

    task automatic m_write(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) m_clk(d[i], s);
        m_clk(1'b1, s);
        ack = ~s;
    endtask

    task automatic m_read(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            m_clk(1'b1, s);
            d[i] = s;
        end
        m_clk(~mack, s);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1ns;
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL reset_sda got=%b exp=1", sda_bus); end
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        total++; if ({rx_valid, tx_req, busy, nack_seen} !== 4'b0)
            begin bad++; $display("FAIL reset_flags got=%b exp=0000", {rx_valid, tx_req, busy, nack_seen}); end
        #50ns reset = 1'b1;
        last_rx = 8'h00;
        #(4*QP);
    endtask

    task automatic test_write();
        logic a0, a1, busy_mid;
        int rx0 = rxv_n;
        m_start();
        m_write({TADDR, 1'b0}, a0);
        m_write(8'hA5, a1);
        busy_mid = busy;
        m_stop();
        #(2*QP);
        last_rx = 8'hA5;
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL wr_addr_ack got=%b exp=1", a0); end
        total++; if (a1 !== 1'b1) begin bad++; $display("FAIL wr_data_ack got=%b exp=1", a1); end
        total++; if (rx_data !== 8'hA5) begin bad++; $display("FAIL wr_rx_data got=%h exp=a5", rx_data); end
        total++; if (rxv_n - rx0 !== 1) begin bad++; $display("FAIL wr_rx_valid_cnt got=%0d exp=1", rxv_n - rx0); end
        total++; if (busy_mid !== 1'b1) begin bad++; $display("FAIL wr_busy_mid got=%b exp=1", busy_mid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wr_busy_after_stop got=%b exp=0", busy); end
    endtask

    task automatic test_addr_mismatch();
        logic a0, a1;
        int rx0 = rxv_n, l0 = low_n, b0 = busy_n;
        m_start();
        m_write({7'h43, 1'b0}, a0);
        m_write(8'h5A, a1);
        m_stop();
        #(2*QP);
        total++; if (a0 !== 1'b0 || a1 !== 1'b0) begin bad++; $display("FAIL mm_ack got=%b%b exp=00", a0, a1); end
        total++; if (low_n - l0 !== 0) begin bad++; $display("FAIL mm_sda_low got=%0d exp=0", low_n - l0); end
        total++; if (rxv_n - rx0 !== 0) begin bad++; $display("FAIL mm_rx_valid got=%0d exp=0", rxv_n - rx0); end
        total++; if (busy_n - b0 !== 0) begin bad++; $display("FAIL mm_busy got=%0d exp=0", busy_n - b0); end
        total++; if (rx_data !== last_rx) begin bad++; $display("FAIL mm_rx_data got=%h exp=%h", rx_data, last_rx); end
    endtask

    task automatic test_read_two();
        logic a0;
        logic [7:0] d0, d1;
        int t0 = txr_n, n0 = nack_n;
        tx_data = 8'h3C;
        m_start();
        m_write({TADDR, 1'b1}, a0);
        tx_data = 8'hC3;
        m_read(1'b1, d0);
        tx_data = 8'($urandom);
        m_read(1'b0, d1);
        total++; if (a0 !== 1'b1) begin bad++; $display("FAIL rd_addr_ack got=%b exp=1", a0); end
        total++; if (d0 !== 8'h3C) begin bad++; $display("FAIL rd_byte0 got=%h exp=3c", d0); end
        total++; if (d1 !== 8'hC3) begin bad++; $display("FAIL rd_byte1 got=%h exp=c3", d1); end
        total++; if (txr_n - t0 !== 2) begin bad++; $display("FAIL rd_tx_req_cnt got=%0d exp=2", txr_n - t0); end
        total++; if (nack_n - n0 !== 1) begin bad++; $display("FAIL rd_nack_cnt got=%0d exp=1", nack_n - n0); end
        total++; if (busy !== 1'b0 || sda_bus !== 1'b1)
            begin bad++; $display("FAIL rd_after_nack busy=%b sda=%b exp busy=0 sda=1", busy, sda_bus); end
        m_stop();
        #(2*QP);
    endtask

    task automatic test_rep_start();
        logic a0, a1, a2;
        logic [7:0] wd, rv, rd;
        wd = 8'h11;
        rv = 8'($urandom);
        m_start();
        m_write({TADDR, 1'b0}, a0);
        m_write(wd, a1);
        last_rx = wd;
        total++; if (rx_data !== wd) begin bad++; $display("FAIL rs_rx_data got=%h exp=%h", rx_data, wd); end
        tx_data = rv;
        m_start();
        m_write({TADDR, 1'b1}, a2);
        tx_data = 8'($urandom);
        m_read(1'b0, rd);
        m_stop();
        #(2*QP);
        total++; if ({a0, a1, a2} !== 3'b111) begin bad++; $display("FAIL rs_acks got=%b exp=111", {a0, a1, a2}); end
        total++; if (rd !== rv) begin bad++; $display("FAIL rs_read got=%h exp=%h", rd, rv); end
    endtask

    task automatic test_stop_mid();
        logic a0, a1, s;
        int rx0 = rxv_n;
        m_start();
        m_write({TADDR, 1'b0}, a0);
        for (int i = 0; i < 3; i++) m_clk(1'($urandom), s);
        m_stop();
        #(2*QP);
        total++; if (rxv_n - rx0 !== 0) begin bad++; $display("FAIL sm_rx_valid got=%0d exp=0", rxv_n - rx0); end
        total++; if (busy !== 1'b0 || sda_bus !== 1'b1)
            begin bad++; $display("FAIL sm_idle busy=%b sda=%b exp busy=0 sda=1", busy, sda_bus); end
        rx0 = rxv_n;
        m_start();
        m_write({TADDR, 1'b0}, a0);
        m_write(8'h77, a1);
        m_stop();
        #(2*QP);
        last_rx = 8'h77;
        total++; if (a1 !== 1'b1 || rx_data !== 8'h77 || rxv_n - rx0 !== 1)
            begin bad++; $display("FAIL sm_rewrite ack=%b rx=%h cnt=%0d exp ack=1 rx=77 cnt=1", a1, rx_data, rxv_n - rx0); end
    endtask

    task automatic test_reset_mid_read();
        logic a0, a1, a2;
        int rx0, l0, b0;
        tx_data = 8'($urandom) & 8'h7F;
        m_start();
        m_write({TADDR, 1'b1}, a0);
        total++; if (sda_bus !== 1'b0) begin bad++; $display("FAIL rr_drive0 got=%b exp=0", sda_bus); end
        reset = 1'b0;
        #1ns;
        total++; if (sda_bus !== 1'b1) begin bad++; $display("FAIL rr_sda_release got=%b exp=1", sda_bus); end
        total++; if ({rx_data, rx_valid, tx_req, busy, nack_seen} !== 12'h0)
            begin bad++; $display("FAIL rr_outputs got=%h exp=000", {rx_data, rx_valid, tx_req, busy, nack_seen}); end
        #50ns reset = 1'b1;
        last_rx = 8'h00;
        rx0 = rxv_n; l0 = low_n; b0 = busy_n;
        m_write({TADDR, 1'b0}, a1);
        m_write(8'h33, a2);
        m_stop();
        #(2*QP);
        total++; if ({a1, a2} !== 2'b00 || low_n - l0 !== 0)
            begin bad++; $display("FAIL rr_no_start_ack ack=%b low=%0d exp ack=00 low=0", {a1, a2}, low_n - l0); end
        total++; if (rxv_n - rx0 !== 0 || busy_n - b0 !== 0)
            begin bad++; $display("FAIL rr_no_start_act rxv=%0d busy=%0d exp 0", rxv_n - rx0, busy_n - b0); end
    endtask

    // Random transactions; the model only knows: matching address -> ACK and data flow.
    task automatic test_back_to_back();
        for (int t = 0; t < 10; t++) begin
            logic [6:0] addr;
            logic       rw, a0, exp_hit, ak;
            logic [7:0] d, rd;
            int         n, rx0, t0, n0, l0;
            addr = ($urandom_range(0, 2) != 0) ? TADDR : 7'($urandom);
            exp_hit = (addr == TADDR);
            rw = 1'($urandom);
            n = $urandom_range(1, 3);
            rx0 = rxv_n; t0 = txr_n; n0 = nack_n; l0 = low_n;
            tx_data = 8'($urandom);
            d = tx_data;
            m_start();
            m_write({addr, rw}, a0);
            total++; if (a0 !== exp_hit) begin bad++; $display("FAIL b2b_addr_ack t=%0d got=%b exp=%b", t, a0, exp_hit); end
            for (int i = 0; i < n; i++) begin
                if (rw) begin
                    tx_data = 8'($urandom);
                    m_read(i != n - 1, rd);
                    total++; if (rd !== (exp_hit ? d : 8'hFF))
                        begin bad++; $display("FAIL b2b_read t=%0d i=%0d got=%h exp=%h", t, i, rd, exp_hit ? d : 8'hFF); end
                    d = tx_data;
                end else begin
                    d = 8'($urandom);
                    m_write(d, ak);
                    if (exp_hit) last_rx = d;
                    total++; if (ak !== exp_hit || rx_data !== last_rx)
                        begin bad++; $display("FAIL b2b_write t=%0d i=%0d ack=%b rx=%h exp ack=%b rx=%h", t, i, ak, rx_data, exp_hit, last_rx); end
                end
            end
            m_stop();
            #(2*QP);
            total++; if (rxv_n - rx0 !== ((exp_hit && !rw) ? n : 0) ||
                         txr_n - t0 !== ((exp_hit && rw) ? n : 0) ||
                         nack_n - n0 !== ((exp_hit && rw) ? 1 : 0))
                begin bad++; $display("FAIL b2b_counts t=%0d rxv=%0d txr=%0d nack=%0d", t, rxv_n - rx0, txr_n - t0, nack_n - n0); end
            if (!exp_hit) begin
                total++; if (low_n - l0 !== 0) begin bad++; $display("FAIL b2b_mm_low t=%0d got=%0d exp=0", t, low_n - l0); end
            end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_busy_end t=%0d got=%b exp=0", t, busy); end
        end
    endtask

    initial begin
        reset    = 1'b0;
        m_sda_oe = 1'b0;
        m_scl_oe = 1'b0;
        tx_data  = 8'h00;
        #23ns;
        test_reset();
        test_write();
        test_addr_mismatch();
        test_read_two();
        test_rep_start();
        test_stop_mid();
        test_reset_mid_read();
        test_back_to_back();
        total++; if (glitch_n !== 0) begin bad++; $display("FAIL sda_change_scl_high got=%0d exp=0", glitch_n); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
